// File: rtl/xpb_pkg.sv
// xpb_pkg: shared widths, FSM states and accumulator sizing for the XPB reduction path
package xpb_pkg;
    localparam int XPB_CHUNK_W = 5;
    localparam int XPB_DATA_W  = 1024;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} xpb_state_e;

    // lo_in plus one residue per chunk needs this many guard bits to never wrap
    function automatic int xpb_acc_w(input int data_w, input int num_chunks);
        return data_w + $clog2(num_chunks + 2);
    endfunction
endpackage

// File: rtl/xpb_chunk_issue.sv
// xpb_chunk_issue: captures the high part and walks its chunks onto the table address bus
module xpb_chunk_issue
    import xpb_pkg::*;
#(
    parameter int NUM_CHUNKS = 4,
    parameter int CHUNK_W    = XPB_CHUNK_W,
    parameter int SEL_W      = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          step,
    input  logic [NUM_CHUNKS*CHUNK_W-1:0] hi_in,
    output logic [SEL_W-1:0]              lut_sel,
    output logic [CHUNK_W-1:0]            lut_idx,
    output logic                          v,
    output logic                          last
);
    logic [NUM_CHUNKS*CHUNK_W-1:0] hi_q;
    logic [SEL_W-1:0]              nxt;

    assign nxt  = SEL_W'(lut_sel + 1'b1);
    assign last = lut_sel == SEL_W'(NUM_CHUNKS - 1);

    // address registers are preloaded on accept so ISSUE cycles see chunk cnt straight from flops
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q    <= '0;
            lut_sel <= '0;
            lut_idx <= '0;
            v       <= 1'b0;
        end else begin
            v <= step;
            if (load) begin
                hi_q    <= hi_in;
                lut_sel <= '0;
                lut_idx <= hi_in[CHUNK_W-1:0];
            end else if (step && !last) begin
                lut_sel <= nxt;
                lut_idx <= hi_q[nxt*CHUNK_W +: CHUNK_W];
            end
        end
    end
endmodule

// File: rtl/xpb_reduce_seq.sv
// xpb_reduce_seq: sequential XPB reduction, one table lookup per chunk summed with the low part
module xpb_reduce_seq
    import xpb_pkg::*;
#(
    parameter int NUM_CHUNKS = 4,
    parameter int CHUNK_W    = XPB_CHUNK_W,
    parameter int DATA_W     = XPB_DATA_W,
    parameter int ACC_W      = xpb_acc_w(DATA_W, NUM_CHUNKS),
    localparam int SEL_W     = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [NUM_CHUNKS*CHUNK_W-1:0] hi_in,
    input  logic [DATA_W-1:0]             lo_in,
    output logic                          busy,
    output logic [SEL_W-1:0]              lut_sel,
    output logic [CHUNK_W-1:0]            lut_idx,
    input  logic [DATA_W-1:0]             lut_data,
    output logic                          done,
    output logic [ACC_W-1:0]              result
);
    xpb_state_e       state, state_nxt;
    logic             v, last, load;
    logic [ACC_W-1:0] acc, acc_sum;

    assign load    = state == IDLE && start;
    assign acc_sum = acc + ACC_W'(lut_data);

    xpb_chunk_issue #(
        .NUM_CHUNKS(NUM_CHUNKS),
        .CHUNK_W   (CHUNK_W),
        .SEL_W     (SEL_W)
    ) u_issue (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .step   (state == ISSUE),
        .hi_in  (hi_in),
        .lut_sel(lut_sel),
        .lut_idx(lut_idx),
        .v      (v),
        .last   (last)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = state == ISSUE || state == DRAIN;
        done      = state == FIN;
        state_nxt = state == IDLE  ? (start ? ISSUE : IDLE) :
                    state == ISSUE ? (last ? DRAIN : ISSUE) :
                    state == DRAIN ? FIN : IDLE;
    end

    // accumulate returned residues; the final DRAIN add is captured so result is valid with done
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            result <= '0;
        end else begin
            if (load)   acc <= ACC_W'(lo_in);
            else if (v) acc <= acc_sum;
            if (state == DRAIN) result <= v ? acc_sum : acc;
        end
    end
endmodule

// File: tb/tb_xpb_reduce_seq.sv
// tb_xpb_reduce_seq: self-checking bench for two-chunk and four-chunk reduction instances
module tb_xpb_reduce_seq;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start2 = 1'b0, start4 = 1'b0;
    logic [19:0]   hi = '0;
    logic [1023:0] lo = '0;
    bit            mode = 1'b0;

    logic          busy2, done2, busy4, done4;
    logic [0:0]    sel2;
    logic [1:0]    sel4;
    logic [4:0]    idx2, idx4;
    logic [1023:0] lut2, lut4;
    logic [1025:0] result2;
    logic [1026:0] result4;

    int n_tests = 0, n_fail = 0;
    int n_done2 = 0, n_done4 = 0, exp_done2 = 0, exp_done4 = 0;

    always #5 clk = ~clk;

    xpb_reduce_seq #(.NUM_CHUNKS(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .hi_in(hi[9:0]), .lo_in(lo),
        .busy(busy2), .lut_sel(sel2), .lut_idx(idx2), .lut_data(lut2),
        .done(done2), .result(result2)
    );

    xpb_reduce_seq #(.NUM_CHUNKS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .hi_in(hi), .lo_in(lo),
        .busy(busy4), .lut_sel(sel4), .lut_idx(idx4), .lut_data(lut4),
        .done(done4), .result(result4)
    );

    // table entry model: index 0 is zero, otherwise a hash or all-ones in max mode
    function automatic logic [1023:0] tval(input int s, input logic [4:0] i, input bit mx);
        logic [1023:0] r;
        logic [31:0]   w;
        r = '0;
        if (i != 5'd0)
            for (int k = 0; k < 32; k++) begin
                w = (32'(s + 1) * 32'h9E3779B1) ^ ({27'd0, i} * 32'h85EBCA77) ^ (32'(k) * 32'hC2B2AE3D);
                w = w * 32'h27D4EB2F + 32'h165667B1;
                r[k*32 +: 32] = mx ? 32'hFFFF_FFFF : w;
            end
        return r;
    endfunction

    function automatic logic [1026:0] model(input logic [19:0] h, input logic [1023:0] l, input int nc, input bit mx);
        logic [1026:0] s;
        s = {3'b000, l};
        for (int i = 0; i < nc; i++) s = s + {3'b000, tval(i, h[i*5 +: 5], mx)};
        return s;
    endfunction

    // external registered table banks
    always @(posedge clk) begin
        lut2 <= tval(int'(sel2), idx2, mode);
        lut4 <= tval(int'(sel4), idx4, mode);
    end

    always @(negedge clk) begin
        if (done2) n_done2++;
        if (done4) n_done4++;
    end

    task automatic chk(input string nm, input logic [1026:0] act, input logic [1026:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got guard=%h low=%h expected guard=%h low=%h",
                     nm, act[1026:1024], act[255:0], exp[1026:1024], exp[255:0]);
        end
    endtask

    // one job on both instances; cycle k is the k-th cycle after start is sampled
    task automatic run_job(input logic [19:0] h, input logic [1023:0] l, input bit mx,
                           input logic [1026:0] e2, input logic [1026:0] e4);
        hi = h; lo = l; mode = mx; start2 = 1'b1; start4 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start2 = 1'b0; start4 = 1'b0;
            if (k == 1) begin
                chk("busy2", 1027'(busy2), 1027'(1));
                chk("busy4", 1027'(busy4), 1027'(1));
            end
            if (k <= 2) begin
                chk("sel2", 1027'(sel2), 1027'(k - 1));
                chk("idx2", 1027'(idx2), 1027'(h[(k-1)*5 +: 5]));
            end
            if (k <= 4) begin
                chk("sel4", 1027'(sel4), 1027'(k - 1));
                chk("idx4", 1027'(idx4), 1027'(h[(k-1)*5 +: 5]));
            end
            chk("done2", 1027'(done2), 1027'(k == 4));
            chk("done4", 1027'(done4), 1027'(k == 6));
            if (k == 4) chk("result2", {1'b0, result2}, e2);
            if (k == 6) chk("result4", result4, e4);
        end
        exp_done2++; exp_done4++;
    endtask

    typedef struct {
        logic [19:0]   hi;
        logic [1023:0] lo;
        bit            mx;
        logic [1026:0] e2;
        logic [1026:0] e4;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [19:0]   a, b, c;
        logic [1023:0] l;
        int            snap;

        vecs[0] = '{20'h00000, 1024'd0, 1'b0, '0, '0};
        vecs[1] = '{20'h00001, 1024'd5, 1'b0, '0, '0};
        vecs[2] = '{20'hFFFFF, {1024{1'b1}}, 1'b1, '0, '0};
        vecs[3] = '{20'hFFFFF, 1024'd0, 1'b0, '0, '0};
        vecs[4] = '{{5'd3, 5'd0, 5'd17, 5'd9}, 1024'd123, 1'b0, '0, '0};
        for (int i = 0; i < 5; i++) begin
            vecs[i].e2 = model(vecs[i].hi, vecs[i].lo, 2, vecs[i].mx);
            vecs[i].e4 = model(vecs[i].hi, vecs[i].lo, 4, vecs[i].mx);
        end

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy2", 1027'(busy2), 1027'(0));
        chk("rst_done2", 1027'(done2), 1027'(0));
        chk("rst_result2", {1'b0, result2}, 1027'(0));
        chk("rst_sel2", 1027'(sel2), 1027'(0));
        chk("rst_idx2", 1027'(idx2), 1027'(0));
        chk("rst_busy4", 1027'(busy4), 1027'(0));
        chk("rst_done4", 1027'(done4), 1027'(0));
        chk("rst_result4", result4, 1027'(0));
        chk("rst_sel4", 1027'(sel4), 1027'(0));
        chk("rst_idx4", 1027'(idx4), 1027'(0));

        for (int i = 0; i < 5; i++) begin
            run_job(vecs[i].hi, vecs[i].lo, vecs[i].mx, vecs[i].e2, vecs[i].e4);
            if (i == 2) chk("guard4_nonzero", 1027'(result4[1026:1024] != 3'd0), 1027'(1));
        end

        // start while busy and in FIN is ignored; held start fires on the next IDLE cycle
        a = 20'h8C3A5; b = 20'h1F00F; c = 20'h5A5A5; l = 1024'hDEAD_BEEF_0123;
        hi = a; lo = l; mode = 1'b0; start4 = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1 || k == 3 || k == 8) start4 = 1'b0;
            if (k == 2) begin start4 = 1'b1; hi = b; end
            chk("ign_done4", 1027'(done4), 1027'(k == 6 || k == 13));
            if (k == 6) begin
                chk("ign_result_a", result4, model(a, l, 4, 1'b0));
                start4 = 1'b1; hi = c;
            end
            if (k == 7) chk("fin_start_ignored", 1027'(busy4), 1027'(0));
            if (k == 8) chk("job2_busy", 1027'(busy4), 1027'(1));
            if (k == 13) chk("ign_result_c", result4, model(c, l, 4, 1'b0));
        end
        exp_done4 += 2;

        // reset during cycle 2 abandons the job
        hi = 20'hABCDE; lo = 1024'h77; start2 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; start4 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy2", 1027'(busy2), 1027'(0));
        chk("mid_rst_done2", 1027'(done2), 1027'(0));
        chk("mid_rst_result2", {1'b0, result2}, 1027'(0));
        chk("mid_rst_busy4", 1027'(busy4), 1027'(0));
        chk("mid_rst_done4", 1027'(done4), 1027'(0));
        chk("mid_rst_result4", result4, 1027'(0));
        snap = n_done4;
        repeat (10) @(negedge clk);
        chk("no_done_after_rst", 1027'(n_done4), 1027'(snap));
        run_job(20'h13579, 1024'h2468, 1'b0, model(20'h13579, 1024'h2468, 2, 1'b0),
                model(20'h13579, 1024'h2468, 4, 1'b0));

        for (int j = 0; j < 200; j++) begin
            a = 20'($urandom);
            for (int k = 0; k < 32; k++) l[k*32 +: 32] = $urandom;
            run_job(a, l, 1'b0, model(a, l, 2, 1'b0), model(a, l, 4, 1'b0));
        end

        chk("done_count2", 1027'(n_done2), 1027'(exp_done2));
        chk("done_count4", 1027'(n_done4), 1027'(exp_done4));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
